// File: rtl/fft_pkg.sv
// ============================================================================
//  Module      : fft_pkg
//  Description : Shared constants, state encoding, twiddle tables and index
//                helpers for the 32-point radix-2 butterfly sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fft_pkg;

    localparam int I_DEF   = 19;
    localparam int F_DEF   = 11;
    localparam int N       = 32;
    localparam int LOGN    = 5;

    // Twiddle tables are stored with TW_FRAC fractional bits and rescaled to F.
    localparam int TW_FRAC = 11;

    localparam int TW_R [16] = '{
         2048,  2009,  1892,  1703,  1448,  1138,   784,   400,
            0,  -400,  -784, -1138, -1448, -1703, -1892, -2009
    };

    localparam int TW_I [16] = '{
            0,  -400,  -784, -1138, -1448, -1703, -1892, -2009,
        -2048, -2009, -1892, -1703, -1448, -1138,  -784,  -400
    };

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_CALC   = 2'd1,
        ST_UNLOAD = 2'd2
    } state_t;

    function automatic logic [LOGN-1:0] bitrev5(input logic [LOGN-1:0] v);
        logic [LOGN-1:0] r;
        for (int b = 0; b < LOGN; b++) begin
            r[b] = v[LOGN-1-b];
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/butterfly_sequencer_mac.sv
// ============================================================================
//  Module      : MAC
//  Description : Combinational radix-2 DIT butterfly: OUT1 = IN1 + IN2*W,
//                OUT2 = IN1 - IN2*W, product truncated back to Q(I.F).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module MAC #(
    parameter int I = 19,
    parameter int F = 11
) (
    input  logic signed [I+F-1:0] i_in1_r,
    input  logic signed [I+F-1:0] i_in1_i,
    input  logic signed [I+F-1:0] i_in2_r,
    input  logic signed [I+F-1:0] i_in2_i,
    input  logic signed [I+F-1:0] i_w_r,
    input  logic signed [I+F-1:0] i_w_i,
    output logic signed [I+F-1:0] o_out1_r,
    output logic signed [I+F-1:0] o_out1_i,
    output logic signed [I+F-1:0] o_out2_r,
    output logic signed [I+F-1:0] o_out2_i
);

    localparam int WD = I + F;
    localparam int PW = 2 * WD;

    logic signed [PW-1:0] w_p_rr;
    logic signed [PW-1:0] w_p_ii;
    logic signed [PW-1:0] w_p_ri;
    logic signed [PW-1:0] w_p_ir;
    logic signed [PW-1:0] w_acc_r;
    logic signed [PW-1:0] w_acc_i;
    logic signed [WD-1:0] w_t_r;
    logic signed [WD-1:0] w_t_i;

    assign w_p_rr  = i_in2_r * i_w_r;
    assign w_p_ii  = i_in2_i * i_w_i;
    assign w_p_ri  = i_in2_r * i_w_i;
    assign w_p_ir  = i_in2_i * i_w_r;

    assign w_acc_r = w_p_rr - w_p_ii;
    assign w_acc_i = w_p_ri + w_p_ir;

    // Keeps product bits [I+2F-1:F]; the shift floors toward -inf.
    assign w_t_r   = WD'(w_acc_r >>> F);
    assign w_t_i   = WD'(w_acc_i >>> F);

    assign o_out1_r = i_in1_r + w_t_r;
    assign o_out1_i = i_in1_i + w_t_i;
    assign o_out2_r = i_in1_r - w_t_r;
    assign o_out2_i = i_in1_i - w_t_i;

endmodule

`default_nettype wire

// File: rtl/butterfly_sequencer.sv
// ============================================================================
//  Module      : butterfly_sequencer
//  Description : 32-point in-place radix-2 DIT FFT with streaming load/unload
//                and one butterfly per cycle through a single shared MAC.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module butterfly_sequencer
    import fft_pkg::*;
#(
    parameter int I = I_DEF,
    parameter int F = F_DEF
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 IN_VALID,
    input  logic signed [I+F-1:0] IN_R,
    input  logic signed [I+F-1:0] IN_I,
    output logic                 IN_READY,
    output logic                 OUT_VALID,
    output logic signed [I+F-1:0] OUT_R,
    output logic signed [I+F-1:0] OUT_I,
    input  logic                 OUT_READY,
    output logic                 BUSY,
    output logic                 FRAME_DONE
);

    localparam int W     = I + F;
    localparam int TW_UP = (F >= TW_FRAC) ? (F - TW_FRAC) : 0;
    localparam int TW_DN = (F <  TW_FRAC) ? (TW_FRAC - F) : 0;

    // Rescale a stored twiddle to F fractional bits (rounded when narrowing).
    function automatic logic signed [W-1:0] tw_scale(input int v);
        longint t;
        t = longint'(v) <<< TW_UP;
        if (TW_DN > 0) begin
            t = (t + ((longint'(1) <<< TW_DN) >>> 1)) >>> TW_DN;
        end
        return W'(t);
    endfunction

    state_t              r_state;
    logic [LOGN-1:0]     r_cnt;
    logic [LOGN-1:0]     r_ocnt;
    logic [2:0]          r_stage;
    logic [3:0]          r_bfly;
    logic                r_in_ready;
    logic                r_out_valid;
    logic                r_busy;
    logic                r_frame_done;

    logic signed [W-1:0] r_mem_r [N];
    logic signed [W-1:0] r_mem_i [N];

    logic [LOGN-1:0]     w_half;
    logic [LOGN-1:0]     w_top;
    logic [LOGN-1:0]     w_bot;
    logic [3:0]          w_k;
    logic signed [W-1:0] w_tw_r;
    logic signed [W-1:0] w_tw_i;
    logic signed [W-1:0] w_out1_r;
    logic signed [W-1:0] w_out1_i;
    logic signed [W-1:0] w_out2_r;
    logic signed [W-1:0] w_out2_i;

    always_comb begin
        w_half = 5'd1 << r_stage;
        w_top  = ((5'(r_bfly) >> r_stage) << (r_stage + 3'd1))
               | (5'(r_bfly) & (w_half - 5'd1));
        w_bot  = w_top + w_half;
        w_k    = 4'((5'(r_bfly) & (w_half - 5'd1)) << (3'd4 - r_stage));
        w_tw_r = tw_scale(TW_R[w_k]);
        w_tw_i = tw_scale(TW_I[w_k]);
    end

    MAC #(
        .I (I),
        .F (F)
    ) u_mac (
        .i_in1_r  (r_mem_r[w_top]),
        .i_in1_i  (r_mem_i[w_top]),
        .i_in2_r  (r_mem_r[w_bot]),
        .i_in2_i  (r_mem_i[w_bot]),
        .i_w_r    (w_tw_r),
        .i_w_i    (w_tw_i),
        .o_out1_r (w_out1_r),
        .o_out1_i (w_out1_i),
        .o_out2_r (w_out2_r),
        .o_out2_i (w_out2_i)
    );

    // Sample storage; contents survive reset since every frame rewrites all 32.
    always_ff @(posedge CLK) begin
        if (RST) begin
            if (r_state == ST_LOAD && IN_VALID) begin
                r_mem_r[bitrev5(r_cnt)] <= IN_R;
                r_mem_i[bitrev5(r_cnt)] <= IN_I;
            end else if (r_state == ST_CALC) begin
                r_mem_r[w_top] <= w_out1_r;
                r_mem_i[w_top] <= w_out1_i;
                r_mem_r[w_bot] <= w_out2_r;
                r_mem_i[w_bot] <= w_out2_i;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state      <= ST_LOAD;
            r_cnt        <= '0;
            r_ocnt       <= '0;
            r_stage      <= '0;
            r_bfly       <= '0;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_LOAD: begin
                    if (IN_VALID) begin
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == 5'd31) begin
                            r_state    <= ST_CALC;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b1;
                        end
                    end
                end
                ST_CALC: begin
                    if (r_bfly == 4'd15) begin
                        r_bfly <= '0;
                        if (r_stage == 3'd4) begin
                            r_stage     <= '0;
                            r_state     <= ST_UNLOAD;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_stage <= r_stage + 3'd1;
                        end
                    end else begin
                        r_bfly <= r_bfly + 4'd1;
                    end
                end
                ST_UNLOAD: begin
                    if (OUT_READY) begin
                        r_ocnt <= r_ocnt + 5'd1;
                        if (r_ocnt == 5'd31) begin
                            r_state      <= ST_LOAD;
                            r_out_valid  <= 1'b0;
                            r_busy       <= 1'b0;
                            r_in_ready   <= 1'b1;
                            r_frame_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_LOAD;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign IN_READY   = r_in_ready;
    assign OUT_VALID  = r_out_valid;
    assign BUSY       = r_busy;
    assign FRAME_DONE = r_frame_done;
    assign OUT_R      = r_out_valid ? r_mem_r[r_ocnt] : '0;
    assign OUT_I      = r_out_valid ? r_mem_i[r_ocnt] : '0;

endmodule

`default_nettype wire

// File: tb/tb_butterfly_sequencer.sv
// ============================================================================
//  Module      : tb_butterfly_sequencer
//  Description : Directed self-checking bench for butterfly_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_butterfly_sequencer;

    localparam int I = 19;
    localparam int F = 11;
    localparam int W = I + F;

    logic                CLK = 1'b0;
    logic                RST = 1'b0;
    logic                IN_VALID = 1'b0;
    logic signed [W-1:0] IN_R = '0;
    logic signed [W-1:0] IN_I = '0;
    logic                OUT_READY = 1'b0;
    logic                IN_READY;
    logic                OUT_VALID;
    logic signed [W-1:0] OUT_R;
    logic signed [W-1:0] OUT_I;
    logic                BUSY;
    logic                FRAME_DONE;

    butterfly_sequencer #(
        .I (I),
        .F (F)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .IN_VALID   (IN_VALID),
        .IN_R       (IN_R),
        .IN_I       (IN_I),
        .IN_READY   (IN_READY),
        .OUT_VALID  (OUT_VALID),
        .OUT_R      (OUT_R),
        .OUT_I      (OUT_I),
        .OUT_READY  (OUT_READY),
        .BUSY       (BUSY),
        .FRAME_DONE (FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic signed [W-1:0] xr [32];
    logic signed [W-1:0] xi [32];
    logic signed [W-1:0] yr [32];
    logic signed [W-1:0] yi [32];
    logic signed [W-1:0] refr [32];
    logic signed [W-1:0] refi [32];

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_near(input string tag, input logic signed [63:0] obs, input longint exp);
        checks++;
        assert (obs >= exp - 64 && obs <= exp + 64) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d +/-64", tag, obs, exp);
        end
    endtask

    // round(2048*cos(2*pi*n/32)) built from the first quarter wave
    function automatic int cosq(input int n);
        int c [9];
        int m;
        c = '{2048, 2009, 1892, 1703, 1448, 1138, 784, 400, 0};
        m = n % 32;
        if (m <= 8)       return c[m];
        else if (m <= 16) return -c[16-m];
        else if (m <= 24) return -c[m-16];
        else              return c[32-m];
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_frame(input bit gaps, input bit wait_calc);
        int cyc;
        chk("in_ready_at_load", IN_READY, 1);
        for (int n = 0; n < 32; n++) begin
            if (gaps) begin
                IN_VALID = 1'b0;
                IN_R     = W'(999);
                step();
            end
            IN_VALID = 1'b1;
            IN_R     = xr[n];
            IN_I     = xi[n];
            step();
            if (n == 0) chk("frame_done_cleared", FRAME_DONE, 0);
        end
        // Junk presented while not loading must be ignored.
        IN_R = W'(12345);
        IN_I = W'(-777);
        chk("in_ready_low_after_31", IN_READY, 0);
        chk("busy_in_calc", BUSY, 1);
        if (wait_calc) begin
            cyc = 0;
            while (!OUT_VALID && cyc < 200) begin
                step();
                cyc++;
            end
            chk("calc_cycles", cyc, 80);
        end
        IN_VALID = 1'b0;
    endtask

    task automatic unload(input bit stall);
        int idx;
        int cyc;
        bit held;
        bit unstable;
        bit early_done;
        logic signed [W-1:0] hold_r;
        logic signed [W-1:0] hold_i;
        idx = 0; cyc = 0; held = 0; unstable = 0; early_done = 0;
        hold_r = '0; hold_i = '0;
        while (idx < 32 && cyc < 1000) begin
            OUT_READY = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (FRAME_DONE) early_done = 1;
            if (held && (OUT_R !== hold_r || OUT_I !== hold_i || OUT_VALID !== 1'b1)) unstable = 1;
            held = 0;
            if (OUT_VALID && OUT_READY) begin
                yr[idx] = OUT_R;
                yi[idx] = OUT_I;
                idx++;
            end else if (OUT_VALID) begin
                held   = 1;
                hold_r = OUT_R;
                hold_i = OUT_I;
            end
            step();
            cyc++;
        end
        OUT_READY = 1'b0;
        chk("unload_count", idx, 32);
        chk("stall_data_stable", unstable, 0);
        chk("frame_done_early", early_done, 0);
        chk("frame_done_pulse", FRAME_DONE, 1);
        chk("in_ready_after_frame", IN_READY, 1);
        chk("out_valid_after_frame", OUT_VALID, 0);
        chk("busy_after_frame", BUSY, 0);
    endtask

    task automatic set_impulse();
        for (int n = 0; n < 32; n++) begin
            xr[n] = (n == 0) ? W'(2048) : '0;
            xi[n] = '0;
        end
    endtask

    task automatic check_impulse(input string tag);
        for (int k = 0; k < 32; k++) begin
            chk($sformatf("%s_re[%0d]", tag, k), yr[k], 2048);
            chk($sformatf("%s_im[%0d]", tag, k), yi[k], 0);
        end
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_in_ready", IN_READY, 1);
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_frame_done", FRAME_DONE, 0);
        chk("rst_out_r", OUT_R, 0);
        chk("rst_out_i", OUT_I, 0);
        RST = 1'b1;
        step();

        // Impulse
        set_impulse();
        load_frame(0, 1);
        unload(0);
        check_impulse("impulse");

        // DC, loaded back-to-back in the FRAME_DONE cycle
        for (int n = 0; n < 32; n++) begin
            xr[n] = W'(2048);
            xi[n] = '0;
        end
        load_frame(0, 1);
        unload(0);
        for (int k = 0; k < 32; k++) begin
            chk($sformatf("dc_re[%0d]", k), yr[k], (k == 0) ? 65536 : 0);
            chk($sformatf("dc_im[%0d]", k), yi[k], 0);
        end

        // Real cosine tone at bin 1
        for (int n = 0; n < 32; n++) begin
            xr[n] = W'(cosq(n));
            xi[n] = '0;
        end
        load_frame(0, 1);
        unload(0);
        for (int k = 0; k < 32; k++) begin
            chk_near($sformatf("cos_re[%0d]", k), yr[k], (k == 1 || k == 31) ? 32768 : 0);
            chk_near($sformatf("cos_im[%0d]", k), yi[k], 0);
        end

        // Complex exponential: energy only in bin 1
        for (int n = 0; n < 32; n++) begin
            xr[n] = W'(cosq(n));
            xi[n] = W'(cosq(n + 24));
        end
        load_frame(0, 1);
        unload(0);
        for (int k = 0; k < 32; k++) begin
            chk_near($sformatf("cexp_re[%0d]", k), yr[k], (k == 1) ? 65536 : 0);
            chk_near($sformatf("cexp_im[%0d]", k), yi[k], 0);
            refr[k] = yr[k];
            refi[k] = yi[k];
        end

        // Same frame with input gaps and random output backpressure
        load_frame(1, 1);
        unload(1);
        for (int k = 0; k < 32; k++) begin
            chk($sformatf("stall_re[%0d]", k), yr[k], refr[k]);
            chk($sformatf("stall_im[%0d]", k), yi[k], refi[k]);
        end

        // Reset in the middle of CALC
        for (int n = 0; n < 32; n++) begin
            xr[n] = W'(2048);
            xi[n] = W'(-300);
        end
        load_frame(0, 0);
        repeat (40) step();
        chk("mid_calc_busy", BUSY, 1);
        RST = 1'b0;
        step();
        RST = 1'b1;
        chk("post_rst_in_ready", IN_READY, 1);
        chk("post_rst_out_valid", OUT_VALID, 0);
        chk("post_rst_busy", BUSY, 0);
        chk("post_rst_out_r", OUT_R, 0);
        set_impulse();
        load_frame(0, 1);
        unload(0);
        check_impulse("post_rst_impulse");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
